// File: rtl/delay_tap_pkg.sv
// Shared types and helpers for the multi-channel delay tap controller.
// Optional feature macro: DELAY_TAP_WAIT_EDGE_EN (adds PEND state / EDGE qualifier).
package delay_tap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PEND   = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    // Saturated next tap: never wraps past 0 or max.
    function automatic logic [31:0] tap_step(
        input logic [31:0] tap,
        input logic        dir,
        input logic [31:0] max
    );
        logic [31:0] nxt;
        nxt = tap;
        if (!dir && tap != max)
            nxt = tap + 32'd1;
        else if (dir && tap != 32'd0)
            nxt = tap - 32'd1;
        return nxt;
    endfunction

    // Saturation flag: sitting at the end the last move pointed towards.
    function automatic logic sat_flag(
        input logic [31:0] tap,
        input logic        dir,
        input logic [31:0] max
    );
        return (tap == max && !dir) || (tap == 32'd0 && dir);
    endfunction

endpackage

// File: rtl/delay_tap_chan.sv
// One delay channel: move-edge detect, saturating tap counter, settle timer.
// Optional feature macro: DELAY_TAP_WAIT_EDGE_EN (step deferred to qual falling edge).
module delay_tap_chan
    import delay_tap_pkg::*;
#(
    parameter int TAP_WIDTH = 7,
    parameter int DEL_VALUE = 0,
    parameter int MOVE_GAP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_n,
    input  logic                 move,
    input  logic                 direction,
`ifdef DELAY_TAP_WAIT_EDGE_EN
    input  logic                 qual,
`endif
    output logic [TAP_WIDTH-1:0] tap,
    output logic                 cflag,
    output logic                 busy
);

    localparam logic [TAP_WIDTH-1:0] TAP_MAX  = {TAP_WIDTH{1'b1}};
    localparam logic [TAP_WIDTH-1:0] TAP_INIT = TAP_WIDTH'(DEL_VALUE);
    localparam logic [CNT_W-1:0]     GAP_LD   = CNT_W'(MOVE_GAP - 1);
    localparam logic                 INIT_FLG =
        (TAP_INIT == TAP_MAX);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 move_q;
    logic                 dir_q;
    logic                 move_ev;
    logic                 qual_fall;
    logic [TAP_WIDTH-1:0] tap_now;
    logic [TAP_WIDTH-1:0] tap_pend;

    assign move_ev = move_q && !move;

`ifdef DELAY_TAP_WAIT_EDGE_EN
    logic edge_q;

    // Registered copy of the qualifier for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n)
            edge_q <= 1'b0;
        else
            edge_q <= qual;
    end

    assign qual_fall = edge_q && !qual;
`else
    assign qual_fall = 1'b0;
`endif

    assign tap_now = TAP_WIDTH'(
        tap_step(32'(tap), direction, 32'(TAP_MAX)));
    assign tap_pend = TAP_WIDTH'(
        tap_step(32'(tap), dir_q, 32'(TAP_MAX)));

    // Channel FSM: load beats move; moves ignored while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap    <= TAP_INIT;
            dir_q  <= 1'b0;
            move_q <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
            cflag  <= INIT_FLG;
        end else begin
            move_q <= move;
            if (!load_n) begin
                tap   <= TAP_INIT;
                dir_q <= 1'b0;
                busy  <= 1'b0;
                cnt   <= '0;
                state <= IDLE;
                cflag <= INIT_FLG;
            end else begin
                case (state)
                    IDLE: begin
                        if (move_ev) begin
                            dir_q <= direction;
                            busy  <= 1'b1;
`ifdef DELAY_TAP_WAIT_EDGE_EN
                            state <= PEND;
                            cflag <= sat_flag(32'(tap),
                                direction, 32'(TAP_MAX));
`else
                            tap   <= tap_now;
                            cnt   <= GAP_LD;
                            state <= SETTLE;
                            cflag <= sat_flag(32'(tap_now),
                                direction, 32'(TAP_MAX));
`endif
                        end
                    end
                    PEND: begin
                        if (qual_fall) begin
                            tap   <= tap_pend;
                            cnt   <= GAP_LD;
                            state <= SETTLE;
                            cflag <= sat_flag(32'(tap_pend),
                                dir_q, 32'(TAP_MAX));
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/delay_tap_ctrl.sv
// Multi-channel delay-line tap controller; one delay_tap_chan per channel.
// Optional feature macro: DELAY_TAP_WAIT_EDGE_EN (adds EDGE qualifier port).
module delay_tap_ctrl
    import delay_tap_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int TAP_WIDTH = 7,
    parameter int DEL_VALUE = 0,
    parameter int MOVE_GAP  = 4
) (
    input  logic                          SCLK,
    input  logic                          RSTN,
    input  logic [CHANNELS-1:0]           LOADN,
    input  logic [CHANNELS-1:0]           MOVE,
    input  logic [CHANNELS-1:0]           DIRECTION,
`ifdef DELAY_TAP_WAIT_EDGE_EN
    input  logic [CHANNELS-1:0]           EDGE,
`endif
    output logic [CHANNELS*TAP_WIDTH-1:0] TAP,
    output logic [CHANNELS-1:0]           CFLAG,
    output logic [CHANNELS-1:0]           BUSY
);

    // Independent per-channel controllers.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        delay_tap_chan #(
            .TAP_WIDTH (TAP_WIDTH),
            .DEL_VALUE (DEL_VALUE),
            .MOVE_GAP  (MOVE_GAP)
        ) u_chan (
            .clk       (SCLK),
            .rst_n     (RSTN),
            .load_n    (LOADN[i]),
            .move      (MOVE[i]),
            .direction (DIRECTION[i]),
`ifdef DELAY_TAP_WAIT_EDGE_EN
            .qual      (EDGE[i]),
`endif
            .tap       (TAP[i*TAP_WIDTH +: TAP_WIDTH]),
            .cflag     (CFLAG[i]),
            .busy      (BUSY[i])
        );
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed bench for delay_tap_ctrl (4 channels, 7-bit taps, gap 4).
// Optional feature macro: DELAY_TAP_WAIT_EDGE_EN (EDGE held low here).
module tb_delay_tap_ctrl;

    logic        SCLK;
    logic        RSTN;
    logic [3:0]  LOADN;
    logic [3:0]  MOVE;
    logic [3:0]  DIRECTION;
`ifdef DELAY_TAP_WAIT_EDGE_EN
    logic [3:0]  EDGE;
`endif
    logic [27:0] TAP;
    logic [3:0]  CFLAG;
    logic [3:0]  BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  move;
        logic [3:0]  dir;
        logic [27:0] tap;
        logic [3:0]  cflag;
        logic [3:0]  busy;
    } vec_t;

    vec_t vecs[20];

    delay_tap_ctrl #(
        .CHANNELS  (4),
        .TAP_WIDTH (7),
        .DEL_VALUE (0),
        .MOVE_GAP  (4)
    ) dut (
        .SCLK      (SCLK),
        .RSTN      (RSTN),
        .LOADN     (LOADN),
        .MOVE      (MOVE),
        .DIRECTION (DIRECTION),
`ifdef DELAY_TAP_WAIT_EDGE_EN
        .EDGE      (EDGE),
`endif
        .TAP       (TAP),
        .CFLAG     (CFLAG),
        .BUSY      (BUSY)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    function automatic logic [27:0] taps(int t3, int t2, int t1, int t0);
        return {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
    endfunction

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (BUSY != 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (BUSY != 4'b0000) begin
            errors++;
            $display("FAIL %s_idle got busy %b want 0000", name, BUSY);
        end
    endtask

    // Pulse MOVE on one channel, report outputs right after the event.
    task automatic do_move(input int ch, input logic dir,
                           output logic [6:0] t_o,
                           output logic c_o,
                           output logic b_o);
        MOVE[ch]      = 1'b1;
        DIRECTION[ch] = dir;
        tick();
        MOVE[ch] = 1'b0;
        tick();
        t_o = TAP[ch*7 +: 7];
        c_o = CFLAG[ch];
        b_o = BUSY[ch];
        wait_idle("mv");
    endtask

    initial begin
        logic [6:0] t;
        logic       c;
        logic       b;

        vecs[0]  = '{4'b0001, 4'b0000, taps(0,0,0,0), 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0000, 4'b0001};
        vecs[2]  = '{4'b0001, 4'b0000, taps(0,0,0,1), 4'b0000, 4'b0001};
        vecs[3]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0000, 4'b0001};
        vecs[4]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0000, 4'b0001};
        vecs[5]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0000, 4'b0000};
        vecs[6]  = '{4'b0100, 4'b0100, taps(0,0,0,1), 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0000, 4'b0100, taps(0,0,0,1), 4'b0100, 4'b0100};
        vecs[8]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0100, 4'b0100};
        vecs[9]  = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0100, 4'b0100};
        vecs[10] = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0100, 4'b0100};
        vecs[11] = '{4'b0000, 4'b0000, taps(0,0,0,1), 4'b0100, 4'b0000};
        vecs[12] = '{4'b1001, 4'b0000, taps(0,0,0,1), 4'b0100, 4'b0000};
        vecs[13] = '{4'b0000, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b1001};
        vecs[14] = '{4'b0000, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b1001};
        vecs[15] = '{4'b0000, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b1001};
        vecs[16] = '{4'b0000, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b1001};
        vecs[17] = '{4'b0000, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b0000};
        vecs[18] = '{4'b0100, 4'b0000, taps(1,0,0,2), 4'b0100, 4'b0000};
        vecs[19] = '{4'b0000, 4'b0000, taps(1,1,0,2), 4'b0000, 4'b0100};

        RSTN      = 1'b0;
        LOADN     = 4'b1111;
        MOVE      = 4'b0000;
        DIRECTION = 4'b0000;
`ifdef DELAY_TAP_WAIT_EDGE_EN
        EDGE      = 4'b0000;
`endif
        repeat (3) tick();
        check("rst_tap",   32'(TAP),   32'(taps(0,0,0,0)));
        check("rst_cflag", 32'(CFLAG), 32'h0);
        check("rst_busy",  32'(BUSY),  32'h0);
        RSTN = 1'b1;
        tick();
        check("post_tap",   32'(TAP),   32'(taps(0,0,0,0)));
        check("post_cflag", 32'(CFLAG), 32'h0);
        check("post_busy",  32'(BUSY),  32'h0);

        for (int i = 0; i < 20; i++) begin
            MOVE      = vecs[i].move;
            DIRECTION = vecs[i].dir;
            tick();
            check($sformatf("v%0d_tap", i),
                  32'(TAP), 32'(vecs[i].tap));
            check($sformatf("v%0d_cflag", i),
                  32'(CFLAG), 32'(vecs[i].cflag));
            check($sformatf("v%0d_busy", i),
                  32'(BUSY), 32'(vecs[i].busy));
        end
        MOVE      = 4'b0000;
        DIRECTION = 4'b0000;
        wait_idle("table");

        // Ramp channel 1 to the top, then push into saturation and escape.
        for (int k = 0; k < 127; k++)
            do_move(1, 1'b0, t, c, b);
        check("ramp_tap1",   32'(TAP[13:7]), 32'd127);
        check("ramp_cflag1", 32'(CFLAG[1]),  32'd1);
        do_move(1, 1'b0, t, c, b);
        check("sat_tap1",   32'(t), 32'd127);
        check("sat_cflag1", 32'(c), 32'd1);
        check("sat_busy1",  32'(b), 32'd1);
        do_move(1, 1'b1, t, c, b);
        check("esc_tap1",   32'(t), 32'd126);
        check("esc_cflag1", 32'(c), 32'd0);

        // Load on ch2 collides with its move event; ch3 moves normally.
        MOVE = 4'b1100;
        DIRECTION = 4'b0000;
        tick();
        MOVE  = 4'b0000;
        LOADN = 4'b1011;
        tick();
        check("ld_tap2",   32'(TAP[20:14]), 32'd0);
        check("ld_busy2",  32'(BUSY[2]),    32'd0);
        check("ld_cflag2", 32'(CFLAG[2]),   32'd0);
        check("ld_tap3",   32'(TAP[27:21]), 32'd2);
        check("ld_busy3",  32'(BUSY[3]),    32'd1);
        LOADN = 4'b1111;
        tick();
        check("ld_hold2", 32'(BUSY[2]), 32'd0);
        wait_idle("ld");

        // Reset while channel 0 is settling.
        MOVE[0] = 1'b1;
        tick();
        MOVE[0] = 1'b0;
        tick();
        check("mr_tap0",  32'(TAP[6:0]), 32'd3);
        check("mr_busy0", 32'(BUSY[0]),  32'd1);
        tick();
        RSTN = 1'b0;
        tick();
        check("mr_busy", 32'(BUSY),  32'h0);
        check("mr_tap",  32'(TAP),   32'(taps(0,0,0,0)));
        check("mr_cfl",  32'(CFLAG), 32'h0);
        RSTN = 1'b1;
        tick();
        tick();
        check("mr_after", 32'(BUSY), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
